// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictors: state encoding,
// saturating-counter arithmetic and parameter-legality checking.
package bp_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Widest counter any predictor instance may use.
  localparam int unsigned CTR_MAX_W = 4;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  // Saturating up/down step of a width-bit counter held in a ctr_t.
  function automatic ctr_t sat_ctr_next(input ctr_t ctr, input logic taken,
                                        input int unsigned width);
    ctr_t ctr_max;
    ctr_max = ctr_t'((1 << width) - 1);
    if (taken) begin
      return (ctr == ctr_max) ? ctr : ctr + ctr_t'(1);
    end
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

  // Weakly-not-taken value: just below the taken threshold.
  function automatic ctr_t wnt_init(input int unsigned width);
    return ctr_t'((1 << (width - 1)) - 1);
  endfunction

  // True when a parameter set can be elaborated.
  function automatic bit params_ok(input int unsigned idx_w,
                                   input int unsigned log_entries,
                                   input int unsigned hist_len,
                                   input int unsigned ctr_w,
                                   input int unsigned cnt_w);
    return (log_entries >= 2) && (log_entries <= 16) &&
           (hist_len >= 1) && (hist_len <= log_entries) &&
           (ctr_w >= 2) && (ctr_w <= CTR_MAX_W) &&
           (idx_w >= log_entries + 2) &&
           (cnt_w >= 1) && (cnt_w <= 32);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern-history table: saturating counters with one combinational read
// port, one read-modify-write update port (read-before-write against the
// read port) and the post-reset initialisation sweep that drives ready.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned LOG_ENTRIES = 10,
  parameter int unsigned CTR_W       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   ready,
  input  logic [LOG_ENTRIES-1:0] rd_idx,
  output logic [CTR_W-1:0]       rd_ctr,
  input  logic                   upd_en,
  input  logic [LOG_ENTRIES-1:0] upd_idx,
  input  logic                   upd_taken
);

  localparam int unsigned      ENTRIES  = 1 << LOG_ENTRIES;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(wnt_init(CTR_W));

  logic [CTR_W-1:0]       mem [ENTRIES];
  bp_state_e              state_q;
  logic [LOG_ENTRIES-1:0] ptr_q;
  ctr_t                   upd_old;
  ctr_t                   upd_new;
  logic [CTR_W-1:0]       upd_ctr;

  // Reads see the array before any same-edge write lands.
  assign rd_ctr = mem[rd_idx];
  assign ready  = (state_q == RUN);

  // Next value of the counter being trained.
  always_comb begin
    upd_old = ctr_t'(mem[upd_idx]);
    upd_new = sat_ctr_next(upd_old, upd_taken, CTR_W);
    upd_ctr = CTR_W'(upd_new);
  end

  // Init sweep: one entry per cycle, then hand over to RUN.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else if (state_q == INIT) begin
      ptr_q <= ptr_q + LOG_ENTRIES'(1);
      if (ptr_q == '1) begin
        state_q <= RUN;
      end
    end
  end

  // Counter storage: sweep writes during INIT, training writes in RUN.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q == INIT) begin
        mem[ptr_q] <= CTR_INIT;
      end else if (upd_en) begin
        mem[upd_idx] <= upd_ctr;
      end
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PHT indexed by address XOR speculative global
// history, with history repair on mispredict and a mispredict counter.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned LOG_ENTRIES = 10,
  parameter int unsigned HIST_LEN    = 10,
  parameter int unsigned CTR_W       = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                ready_o,
  input  logic                predict_en_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic                prediction_o,
  output logic                pred_valid_o,
  output logic [HIST_LEN-1:0] pred_hist_o,
  input  logic                update_en_i,
  input  logic [IDX_W-1:0]    upd_idx_i,
  input  logic [HIST_LEN-1:0] upd_hist_i,
  input  logic                br_result_i,
  input  logic                correct_i,
  output logic [31:0]         mispred_cnt_o
);

  if (!params_ok(IDX_W, LOG_ENTRIES, HIST_LEN, CTR_W, CNT_W)) begin : g_param_check
    $error("gshare_predictor: illegal parameter combination");
  end

  logic                   ready;
  logic                   pred_fire;
  logic                   upd_fire;
  logic                   mispred;
  logic [LOG_ENTRIES-1:0] rd_idx;
  logic [LOG_ENTRIES-1:0] upd_idx;
  logic [CTR_W-1:0]       rd_ctr;
  logic                   pred_bit_p0;
  logic [HIST_LEN-1:0]    ghr_q;
  logic [HIST_LEN-1:0]    ghr_d;
  logic                   vld_p1;
  logic                   pred_p1;
  logic [HIST_LEN-1:0]    hist_p1;
  logic [CNT_W-1:0]       mispred_cnt_q;
  logic                   unused_bits;

  // Gshare hash: word address bits folded with zero-extended history.
  function automatic logic [LOG_ENTRIES-1:0] pht_hash(input logic [IDX_W-1:0] addr,
                                                      input logic [HIST_LEN-1:0] hist);
    return addr[LOG_ENTRIES+1:2] ^ LOG_ENTRIES'(hist);
  endfunction

  // Shift one outcome into the youngest history position.
  function automatic logic [HIST_LEN-1:0] hist_shift(input logic [HIST_LEN-1:0] hist,
                                                     input logic bit_in);
    return HIST_LEN'({hist, bit_in});
  endfunction

  assign pred_fire   = predict_en_i & ready;
  assign upd_fire    = update_en_i & ready;
  assign mispred     = upd_fire & ~correct_i;
  assign rd_idx      = pht_hash(idx_i, ghr_q);
  assign upd_idx     = pht_hash(upd_idx_i, upd_hist_i);
  assign pred_bit_p0 = rd_ctr[CTR_W-1];

  // Upper address bits and low counter bits do not feed any decision.
  assign unused_bits = ^{idx_i, upd_idx_i, rd_ctr};

  bp_pht #(
    .LOG_ENTRIES (LOG_ENTRIES),
    .CTR_W       (CTR_W)
  ) u_pht (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ready     (ready),
    .rd_idx    (rd_idx),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_fire),
    .upd_idx   (upd_idx),
    .upd_taken (br_result_i)
  );

  // Next GHR: a repair wins over the same-cycle speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispred) begin
      ghr_d = hist_shift(upd_hist_i, br_result_i);
    end else if (pred_fire) begin
      ghr_d = hist_shift(ghr_q, pred_bit_p0);
    end
  end

  // ---- stage p0 -> p1: history, valid and mispredict counter ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ghr_q         <= '0;
      vld_p1        <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      vld_p1 <= pred_fire;
      if (mispred) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  // Prediction payload registered with the history snapshot it used.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pred_p1 <= 1'b0;
      hist_p1 <= '0;
    end else if (pred_fire) begin
      pred_p1 <= pred_bit_p0;
      hist_p1 <= ghr_q;
    end
  end

  assign ready_o       = ready;
  assign pred_valid_o  = vld_p1;
  assign prediction_o  = pred_p1;
  assign pred_hist_o   = hist_p1;
  assign mispred_cnt_o = 32'(mispred_cnt_q);

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomised self-checking bench for gshare_predictor against a
// behavioural table/history model (mispredict counter built 6 bits wide).
module tb_gshare_predictor;

  localparam int ENTRIES = 1024;
  localparam int HMOD    = 1024;
  localparam int CMOD    = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ready_o;
  logic        predict_en_i = 1'b0;
  logic [31:0] idx_i = '0;
  logic        prediction_o;
  logic        pred_valid_o;
  logic [9:0]  pred_hist_o;
  logic        update_en_i = 1'b0;
  logic [31:0] upd_idx_i = '0;
  logic [9:0]  upd_hist_i = '0;
  logic        br_result_i = 1'b0;
  logic        correct_i = 1'b1;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  int ctr_m [ENTRIES];
  int ghr_m;
  int cnt_m;
  int last_hist;

  gshare_predictor #(
    .IDX_W       (32),
    .LOG_ENTRIES (10),
    .HIST_LEN    (10),
    .CTR_W       (2),
    .CNT_W       (6)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ready_o       (ready_o),
    .predict_en_i  (predict_en_i),
    .idx_i         (idx_i),
    .prediction_o  (prediction_o),
    .pred_valid_o  (pred_valid_o),
    .pred_hist_o   (pred_hist_o),
    .update_en_i   (update_en_i),
    .upd_idx_i     (upd_idx_i),
    .upd_hist_i    (upd_hist_i),
    .br_result_i   (br_result_i),
    .correct_i     (correct_i),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) ctr_m[i] = 1;
    ghr_m = 0;
    cnt_m = 0;
    last_hist = 0;
  endtask

  // One cycle of traffic: drive, advance the model, then compare.
  task automatic step(input bit pe, input logic [31:0] pidx, input bit ue,
                      input logic [31:0] uidx, input int uh, input bit res, input bit cor);
    int pi, ui, exp_hist;
    bit exp_pred;
    predict_en_i = pe;
    idx_i        = pidx;
    update_en_i  = ue;
    upd_idx_i    = uidx;
    upd_hist_i   = 10'(uh);
    br_result_i  = res;
    correct_i    = cor;
    exp_hist = ghr_m;
    exp_pred = 1'b0;
    if (pe) begin
      pi = int'(pidx[11:2]) ^ ghr_m;
      exp_pred = (ctr_m[pi] >= 2);
    end
    if (ue) begin
      ui = int'(uidx[11:2]) ^ uh;
      if (res) begin
        if (ctr_m[ui] < 3) ctr_m[ui]++;
      end else if (ctr_m[ui] > 0) begin
        ctr_m[ui]--;
      end
    end
    if (ue && !cor) begin
      ghr_m = (uh * 2 + int'(res)) % HMOD;
      cnt_m = (cnt_m + 1) % CMOD;
    end else if (pe) begin
      ghr_m = (ghr_m * 2 + int'(exp_pred)) % HMOD;
    end
    @(posedge clk_i);
    #1;
    chk("pred_valid", 32'(pred_valid_o), 32'(pe));
    if (pe) begin
      chk("prediction", 32'(prediction_o), 32'(exp_pred));
      chk("pred_hist", 32'(pred_hist_o), 32'(exp_hist));
      last_hist = exp_hist;
    end
    chk("mispred_cnt", mispred_cnt_o, 32'(cnt_m));
    predict_en_i = 1'b0;
    update_en_i  = 1'b0;
  endtask

  // Force the model and DUT history to v through a repair.
  task automatic set_ghr(input int v);
    step(1'b0, 32'h0, 1'b1, 32'h0, v / 2, v[0], 1'b0);
  endtask

  task automatic predict(input logic [31:0] pidx);
    step(1'b1, pidx, 1'b0, 32'h0, 0, 1'b0, 1'b1);
  endtask

  // Hold reset for three edges and check every reset-visible output.
  task automatic apply_reset();
    rst_ni = 1'b0;
    predict_en_i = 1'b0;
    update_en_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(pred_valid_o), 32'd0);
    chk("rst_pred", 32'(prediction_o), 32'd0);
    chk("rst_hist", 32'(pred_hist_o), 32'd0);
    chk("rst_cnt", mispred_cnt_o, 32'd0);
    rst_ni = 1'b1;
  endtask

  // Count sweep cycles while hammering predict/update, which must be ignored.
  task automatic wait_ready(input string tag);
    int n, stray;
    n = 0;
    stray = 0;
    predict_en_i = 1'b1;
    idx_i        = 32'h0000_0104;
    update_en_i  = 1'b1;
    upd_idx_i    = 32'h0000_0104;
    upd_hist_i   = 10'h0;
    br_result_i  = 1'b1;
    correct_i    = 1'b0;
    while (!ready_o && n < 3000) begin
      @(posedge clk_i);
      #1;
      n++;
      if (pred_valid_o || mispred_cnt_o != 32'd0) stray++;
    end
    predict_en_i = 1'b0;
    update_en_i  = 1'b0;
    correct_i    = 1'b1;
    chk(tag, 32'(n), 32'd1024);
    chk("init_ignored", 32'(stray), 32'd0);
    model_reset();
  endtask

  initial begin
    int g, e, p;
    logic [31:0] pidx, uidx;
    int uh;
    model_reset();

    // Reset and full sweep; first prediction is weakly not-taken.
    apply_reset();
    wait_ready("sweep_len");
    predict(32'h0000_0100);

    // Training to strongly taken.
    step(1'b0, 32'h0, 1'b1, 32'h40, 0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h40, 0, 1'b1, 1'b1);
    predict(32'h0000_0040);

    // Saturation: five taken then one not-taken stays taken.
    set_ghr(0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 32'h80, 0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h80, 0, 1'b0, 1'b1);
    predict(32'h0000_0080);
    // Underflow guard on a fresh entry.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'h300, 0, 1'b0, 1'b1);
    set_ghr(0);
    predict(32'h0000_0300);

    // Speculative history and repair.
    set_ghr(10'h3FF);
    predict(32'h0000_1000);
    predict(32'h0000_1000);
    predict(32'h0000_1000);
    chk("ghr_spec", 32'(ghr_m), 32'h3F8);
    step(1'b0, 32'h0, 1'b1, 32'h0, 10'h155, 1'b1, 1'b0);
    predict(32'h0000_2000);

    // Same-cycle predict and mispredict update on one index.
    set_ghr(10'h0A5);
    e = 10'h1E7;
    g = ghr_m;
    pidx = 32'(((e ^ g) << 2));
    step(1'b1, pidx, 1'b1, pidx, g, 1'b1, 1'b0);
    chk("collide_ghr", 32'(ghr_m), 32'((g * 2 + 1) % HMOD));
    pidx = 32'(((e ^ ghr_m) << 2));
    predict(pidx);

    // Mid-run reset, then mid-sweep reset at pointer 500.
    apply_reset();
    repeat (500) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    chk("mid_sweep_ready", 32'(ready_o), 32'd0);
    rst_ni = 1'b1;
    wait_ready("resweep_len");

    // Random traffic with collisions and counter wrap.
    for (int i = 0; i < 3000; i++) begin
      bit pe, ue, res, cor;
      pe = ($urandom_range(0, 9) < 7);
      ue = ($urandom_range(0, 1) == 1);
      res = ($urandom_range(0, 1) == 1);
      cor = ($urandom_range(0, 3) != 0);
      uh = ($urandom_range(0, 1) == 1) ? last_hist : int'($urandom_range(0, 1023));
      pidx = $urandom;
      p = int'($urandom_range(0, 15)) ^ ghr_m;
      pidx[11:2] = 10'(p);
      uidx = $urandom;
      p = int'($urandom_range(0, 15)) ^ uh;
      uidx[11:2] = 10'(p);
      step(pe, pidx, ue, uidx, uh, res, cor);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
